// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC sequencing controller.
package mac_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Signed add overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, job control and result port of the MAC sequencing controller.
interface mac_seq_ctrl_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    import mac_pkg::*;

    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_acc, out_ovf
    );

endinterface

// File: rtl/BaughWooley_Mult8.sv
// Combinational 8x8 signed multiplier using the modified Baugh-Wooley array.
module BaughWooley_Mult8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    logic [15:0] sum_s;

    // Sign-bit partial products are inverted; the constant 2^15 + 2^8 restores the sign weight.
    always_comb begin
        sum_s = 16'h8100;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7; j++) begin
                sum_s = sum_s + ({15'd0, a_i[i] & b_i[j]} << (i + j));
            end
        end
        for (int k = 0; k < 7; k++) begin
            sum_s = sum_s + ({15'd0, ~(a_i[7] & b_i[k])} << (7 + k));
            sum_s = sum_s + ({15'd0, ~(a_i[k] & b_i[7])} << (7 + k));
        end
        sum_s = sum_s + ({15'd0, a_i[7] & b_i[7]} << 14);
    end

    assign p_o = sum_s;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller: streams operand pairs through one multiplier, accumulates
// the registered products and presents the dot product on a valid/ready result port.
module mac_seq_ctrl #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_seq_ctrl_if.slave bus
);
    import mac_pkg::*;

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    logic [1:0]               state_q, state_d;
    logic [LEN_W-1:0]         rem_q, rem_d;
    logic signed [PROD_W-1:0] p_reg_q, p_reg_d;
    logic                     p_vld_q, p_vld_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic                     ovf_q, ovf_d;
    logic [PROD_W-1:0]        mult_s;
    logic [ACC_W-1:0]         prod_ext_s;
    logic [ACC_W-1:0]         sum_s;
    logic                     add_ovf_s;
    logic                     xfer_s;

    BaughWooley_Mult8 u_mult (
        .a_i (bus.in_a),
        .b_i (bus.in_b),
        .p_o (mult_s)
    );

    assign xfer_s     = (state_q == ST_RUN) && bus.in_valid;
    assign prod_ext_s = ACC_W'($signed(p_reg_q));
    assign sum_s      = acc_q + prod_ext_s;
    assign add_ovf_s  = add_ovf(acc_q[ACC_W-1], prod_ext_s[ACC_W-1], sum_s[ACC_W-1]);

    // Next-state logic: FSM, length counter, product stage and accumulator.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        p_reg_d = p_reg_q;
        p_vld_d = 1'b0;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        if (p_vld_q) begin
            acc_d = sum_s;
            ovf_d = ovf_q | add_ovf_s;
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d = ACC_ZERO;
                    ovf_d = 1'b0;
                    if (bus.len != LEN_ZERO) begin
                        rem_d   = bus.len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    p_reg_d = mult_s;
                    p_vld_d = 1'b1;
                    rem_d   = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    p_vld_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= LEN_ZERO;
            p_reg_q <= 16'sd0;
            p_vld_q <= 1'b0;
            acc_q   <= ACC_ZERO;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            p_reg_q <= p_reg_d;
            p_vld_q <= p_vld_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs are pure decodes of registered state, so reset reaches them at once.
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.in_ready  = (state_q == ST_RUN);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: 24-bit and 16-bit accumulator instances driven in lockstep,
// results scored against a plain-arithmetic dot-product model.
module tb_mac_seq_ctrl;

    typedef struct {
        longint acc;
        bit     ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   qa[$];
    int   qb[$];
    exp_t q24[$];
    exp_t q16[$];

    mac_seq_ctrl_if #(.ACC_W(24), .LEN_W(8)) if24 ();
    mac_seq_ctrl_if #(.ACC_W(16), .LEN_W(8)) if16 ();

    mac_seq_ctrl #(.ACC_W(24), .LEN_W(8)) u_dut24 (.clk(clk), .rst_n(rst_n), .bus(if24));
    mac_seq_ctrl #(.ACC_W(16), .LEN_W(8)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Dot product of the first n pairs, wrapped to w bits, with a sticky overflow flag.
    function automatic exp_t model(input int w, input int n);
        exp_t   e;
        longint span;
        longint hi;
        longint lo;
        span  = longint'(1) <<< w;
        hi    = (span >>> 1) - 1;
        lo    = -(span >>> 1);
        e.acc = 0;
        e.ovf = 1'b0;
        for (int k = 0; k < n; k++) begin
            e.acc = e.acc + longint'(qa[k]) * longint'(qb[k]);
            if (e.acc > hi) begin
                e.acc -= span;
                e.ovf = 1'b1;
            end else if (e.acc < lo) begin
                e.acc += span;
                e.ovf = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic drive_start(input logic s, input int l);
        if24.start = s;  if24.len = 8'(l);
        if16.start = s;  if16.len = 8'(l);
    endtask

    task automatic drive_in(input logic v, input int a, input int b);
        if24.in_valid = v;  if24.in_a = 8'(a);  if24.in_b = 8'(b);
        if16.in_valid = v;  if16.in_a = 8'(a);  if16.in_b = 8'(b);
    endtask

    task automatic drive_ready(input logic r);
        if24.out_ready = r;
        if16.out_ready = r;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      longint'(if24.busy),      0);
        chk({tag, "_in_ready"},  longint'(if24.in_ready),  0);
        chk({tag, "_out_valid"}, longint'(if24.out_valid), 0);
        chk({tag, "_out_acc"},   longint'(if24.out_acc),   0);
        chk({tag, "_out_ovf"},   longint'(if24.out_ovf),   0);
        chk({tag, "_acc16"},     longint'(if16.out_acc),   0);
        chk({tag, "_valid16"},   longint'(if16.out_valid), 0);
    endtask

    // One job of n pairs from qa/qb; gap cycles between pairs, ready_hold cycles of backpressure.
    task automatic run_job(input int n, input int gap_min, input int gap_max,
                           input int ready_hold, input bit noise);
        int lat;
        int tries;
        bit ok;
        bit saw_ready;
        q24.push_back(model(24, n));
        q16.push_back(model(16, n));
        @(posedge clk); #1;
        drive_ready(ready_hold == 0);
        drive_start(1'b1, n);
        @(posedge clk); #1;
        drive_start(1'b0, 0);
        saw_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                repeat ($urandom_range(gap_max, gap_min)) begin
                    drive_in(1'b0, 0, 0);
                    if (noise) drive_start(1'b1, $urandom_range(255, 1));
                    @(posedge clk); #1;
                    drive_start(1'b0, 0);
                end
            end
            drive_in(1'b1, qa[k], qb[k]);
            ok    = 1'b0;
            tries = 0;
            while (!ok && tries < 40) begin
                @(negedge clk);
                ok = if24.in_ready;
                tries++;
                @(posedge clk); #1;
            end
            chk("accept_first_try", tries, 1);
        end
        drive_in(1'b0, 0, 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (if24.in_ready) saw_ready = 1'b1;
        end while (!if24.out_valid && lat < 20);
        chk("out_valid_latency", lat, (n == 0) ? 1 : 2);
        chk("valid16_aligned", longint'(if16.out_valid), 1);
        if (n == 0) chk("len0_in_ready_seen", longint'(saw_ready), 0);
        if (ready_hold > 0) begin
            repeat (ready_hold) begin
                if (noise) drive_start(1'b1, 5);
                @(posedge clk); #1;
                drive_start(1'b0, 0);
            end
            drive_ready(1'b1);
            if (noise) drive_start(1'b1, 3);
            @(posedge clk); #1;
            drive_start(1'b0, 0);
        end
        lat = 0;
        while (if24.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_dropped", longint'(if24.out_valid), 0);
        chk("busy_after_job", longint'(if24.busy), 0);
    endtask

    // Scoreboard monitor: result must match the oldest expectation and hold until accepted.
    always @(negedge clk) begin
        if (rst_n && if24.out_valid) begin
            if (q24.size() == 0) begin
                chk("unexpected_result24", 1, 0);
            end else begin
                chk("acc24", longint'($signed(if24.out_acc)), q24[0].acc);
                if (if24.out_ready) begin
                    chk("ovf24", longint'(if24.out_ovf), longint'(q24[0].ovf));
                    void'(q24.pop_front());
                end
            end
        end
        if (rst_n && if16.out_valid) begin
            if (q16.size() == 0) begin
                chk("unexpected_result16", 1, 0);
            end else begin
                chk("acc16", longint'($signed(if16.out_acc)), q16[0].acc);
                if (if16.out_ready) begin
                    chk("ovf16", longint'(if16.out_ovf), longint'(q16[0].ovf));
                    void'(q16.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        drive_start(1'b0, 0);
        drive_in(1'b0, 0, 0);
        drive_ready(1'b0);
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        qa = {3, -3, 8};  qb = {5, 3, -8};
        run_job(3, 0, 0, 0, 1'b0);

        qa.delete();  qb.delete();
        run_job(0, 0, 0, 0, 1'b0);

        qa = {-128, 127};  qb = {1, 2};
        run_job(2, 3, 3, 5, 1'b1);

        qa.delete();  qb.delete();
        for (int k = 0; k < 255; k++) begin
            qa.push_back(-128);
            qb.push_back(-128);
        end
        run_job(255, 0, 0, 0, 1'b0);

        qa = {-128, -128};  qb = {-128, -128};
        run_job(2, 0, 0, 0, 1'b0);
        qa = {1};  qb = {1};
        run_job(1, 0, 0, 0, 1'b0);

        // Abort a len=4 job after two accepts.
        @(posedge clk); #1;
        drive_ready(1'b1);
        drive_start(1'b1, 4);
        @(posedge clk); #1;
        drive_start(1'b0, 0);
        drive_in(1'b1, 100, 100);
        @(posedge clk); #1;
        drive_in(1'b1, -77, 90);
        @(posedge clk); #1;
        drive_in(1'b0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        q24.delete();
        q16.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        qa = {-5};  qb = {-2};
        run_job(1, 0, 0, 0, 1'b0);

        for (int j = 0; j < 30; j++) begin
            qa.delete();  qb.delete();
            n = $urandom_range(12, 0);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3, 0) == 0) begin
                    qa.push_back(($urandom_range(1, 0) == 1) ? 127 : -128);
                    qb.push_back(-128);
                end else begin
                    qa.push_back(int'($urandom_range(255, 0)) - 128);
                    qb.push_back(int'($urandom_range(255, 0)) - 128);
                end
            end
            run_job(n, 0, 2, $urandom_range(3, 0), $urandom_range(1, 0) == 1);
        end

        repeat (3) @(posedge clk);
        chk("pending24_empty", q24.size(), 0);
        chk("pending16_empty", q16.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
